// File: rtl/layer16x2_seq_mult_ctrl.sv
// Signed 16x16 multiplier sequencer: feeds 2-bit multiplier digits to a shared
// 16x2 partial-product layer and shift-accumulates the results into a 32-bit product.
module layer16x2_seq_mult_ctrl #(
   parameter int width1    = 16,
   parameter int LAYER_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [width1-1:0]     a_in,
   input  logic [width1-1:0]     b_in,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [2*width1-1:0]   product,
   output logic [width1-1:0]     layer_A,
   output logic                  layer_B_low,
   output logic                  layer_B_high,
   output logic                  layer_cin,
   input  logic [width1+1:0]     layer_sum
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [width1-1:0]     a_q, a_d;
   logic [width1-1:0]     b_q, b_d;
   logic [2*width1-1:0]   acc_q, acc_d;
   logic [2*width1-1:0]   product_q, product_d;
   logic [2:0]            k_q, k_d;

   logic [1:0]            digit;
   logic [2*width1-1:0]   pp;
   logic [2*width1-1:0]   acc_sum;
   logic                  accum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         product_q <= '0;
         k_q       <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         k_q       <= k_d;
      end
   end

   assign digit = b_q[{k_q, 1'b0} +: 2];

   // Last digit carries the sign bit at weight -2^15, so subtract 4*a at step 7.
   always_comb begin
      pp = {{(width1-2){layer_sum[width1+1]}}, layer_sum};
      if (k_q == 3'd7 && b_q[width1-1])
         pp = pp - {{(width1-2){a_q[width1-1]}}, a_q, 2'b00};
      acc_sum = acc_q + (pp << {k_q, 1'b0});
   end

   assign accum = (state_q == S_WAIT) || (state_q == S_RUN && LAYER_LAT == 0);

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      product_d = product_q;
      k_d       = k_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a_in;
               b_d     = b_in;
               acc_d   = '0;
               k_d     = '0;
               state_d = S_RUN;
            end
         end
         S_RUN, S_WAIT: begin
            if (accum) begin
               acc_d = acc_sum;
               if (k_q == 3'd7) begin
                  product_d = acc_sum;
                  state_d   = S_DONE;
               end else begin
                  k_d     = k_q + 3'd1;
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_WAIT;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ready        = (state_q == S_IDLE);
      busy         = (state_q == S_RUN) || (state_q == S_WAIT);
      done         = (state_q == S_DONE);
      product      = product_q;
      layer_A      = a_q;
      layer_B_low  = busy ? digit[0] : 1'b0;
      layer_B_high = busy ? digit[1] : 1'b0;
      layer_cin    = 1'b0;
   end

endmodule

// File: tb/tb_layer16x2_seq_mult_ctrl.sv
// Directed bench for layer16x2_seq_mult_ctrl with behavioural 16x2 layer models
// (registered for LAYER_LAT=1, combinational for LAYER_LAT=0).
module tb_layer16x2_seq_mult_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a_in, b_in;

   logic        ready1, busy1, done1, bl1, bh1, cin1;
   logic [31:0] product1;
   logic [15:0] la1;
   logic [17:0] sum1;

   logic        ready0, busy0, done0, bl0, bh0, cin0;
   logic [31:0] product0;
   logic [15:0] la0;
   logic [17:0] sum0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   function automatic logic [17:0] lmodel(input logic [15:0] A, input logic hi, input logic lo);
      int s, d;
      d = 0;
      if (hi) d += 2;
      if (lo) d += 1;
      s = int'($signed(A)) * d;
      return s[17:0];
   endfunction

   always @(posedge clk) sum1 <= lmodel(la1, bh1, bl1);
   assign sum0 = lmodel(la0, bh0, bl0);

   layer16x2_seq_mult_ctrl #(.width1(16), .LAYER_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
      .ready(ready1), .busy(busy1), .done(done1), .product(product1),
      .layer_A(la1), .layer_B_low(bl1), .layer_B_high(bh1), .layer_cin(cin1),
      .layer_sum(sum1)
   );

   layer16x2_seq_mult_ctrl #(.width1(16), .LAYER_LAT(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
      .ready(ready0), .busy(busy0), .done(done0), .product(product0),
      .layer_A(la0), .layer_B_low(bl0), .layer_B_high(bh0), .layer_cin(cin0),
      .layer_sum(sum0)
   );

   // Issues one request (accept edge = cycle 0) and watches 30 cycles.
   // pulse_cyc > 0 raises start with a=1,b=1 during that cycle.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int lat_sel,
                        input int pulse_cyc, output int done_cyc, output int ndone,
                        output logic [31:0] prod, output logic rdy_after);
      logic d;
      a_in = a; b_in = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      done_cyc = -1; ndone = 0; prod = '0; rdy_after = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         d = lat_sel ? done1 : done0;
         if (d) begin
            ndone++;
            if (done_cyc < 0) begin
               done_cyc = c;
               prod = lat_sel ? product1 : product0;
            end
         end
         if (done_cyc >= 0 && c == done_cyc + 1) rdy_after = lat_sel ? ready1 : ready0;
         if (c == pulse_cyc) begin
            start = 1'b1; a_in = 16'd1; b_in = 16'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready1); end
      checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy1); end
      checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done1); end
      checks++; if (product1 !== 32'h0) begin failures++; $display("FAIL reset_product got=%h exp=0", product1); end
      checks++; if ({la1, bh1, bl1, cin1} !== 19'h0) begin failures++; $display("FAIL reset_layer got=%h/%b%b%b exp=0", la1, bh1, bl1, cin1); end
   endtask

   task automatic test_basic();
      int dc, nd; logic [31:0] p; logic r;
      do_op(16'd3, 16'd5, 1, 0, dc, nd, p, r);
      checks++; if (p !== 32'h0000000F) begin failures++; $display("FAIL basic_product got=%h exp=0000000f", p); end
      checks++; if (dc !== 17) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=17", dc); end
      checks++; if (nd !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", nd); end
      checks++; if (r !== 1'b1) begin failures++; $display("FAIL basic_ready_after got=%b exp=1", r); end
   endtask

   task automatic test_signed();
      int dc, nd; logic [31:0] p; logic r;
      do_op(16'h8000, 16'h8000, 1, 0, dc, nd, p, r);
      checks++; if (p !== 32'h40000000) begin failures++; $display("FAIL min_x_min got=%h exp=40000000", p); end
      do_op(16'hFFFF, 16'h0001, 1, 0, dc, nd, p, r);
      checks++; if (p !== 32'hFFFFFFFF) begin failures++; $display("FAIL m1_x_1 got=%h exp=ffffffff", p); end
      do_op(16'h8000, 16'h7FFF, 1, 0, dc, nd, p, r);
      checks++; if (p !== 32'hC0008000) begin failures++; $display("FAIL min_x_max got=%h exp=c0008000", p); end
      do_op(16'd12345, 16'hFFFE, 1, 0, dc, nd, p, r);
      checks++; if (p !== 32'hFFFF9F8E) begin failures++; $display("FAIL lat1_12345_x_m2 got=%h exp=ffff9f8e", p); end
   endtask

   task automatic test_lat0();
      int dc, nd; logic [31:0] p; logic r;
      do_op(16'd12345, 16'hFFFE, 0, 0, dc, nd, p, r);
      checks++; if (p !== 32'hFFFF9F8E) begin failures++; $display("FAIL lat0_product got=%h exp=ffff9f8e", p); end
      checks++; if (dc !== 9) begin failures++; $display("FAIL lat0_done_cycle got=%0d exp=9", dc); end
      checks++; if (r !== 1'b1) begin failures++; $display("FAIL lat0_ready_after got=%b exp=1", r); end
   endtask

   task automatic test_ignored_start();
      int dc, nd; logic [31:0] p; logic r;
      do_op(16'd7, 16'd9, 1, 4, dc, nd, p, r);
      checks++; if (p !== 32'd63) begin failures++; $display("FAIL ignore_product got=%h exp=0000003f", p); end
      checks++; if (nd !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", nd); end
      checks++; if (dc !== 17) begin failures++; $display("FAIL ignore_done_cycle got=%0d exp=17", dc); end
   endtask

   task automatic test_midrun_reset();
      int dc, nd, ndone_after; logic [31:0] p; logic r;
      a_in = 16'd100; b_in = 16'd100; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < 6; c++) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ready1); end
      checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy1); end
      checks++; if (product1 !== 32'h0) begin failures++; $display("FAIL rst_product got=%h exp=0", product1); end
      ndone_after = 0;
      for (int c = 0; c < 20; c++) begin
         if (done1) ndone_after++;
         @(posedge clk); #1;
      end
      checks++; if (ndone_after !== 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", ndone_after); end
      do_op(16'd2, 16'hFFFD, 1, 0, dc, nd, p, r);
      checks++; if (p !== 32'hFFFFFFFA) begin failures++; $display("FAIL rst_then_op got=%h exp=fffffffa", p); end
   endtask

   task automatic test_layer_ports();
      int k;
      logic [1:0] exp_d;
      logic [31:0] p;
      int ndone;
      a_in = 16'd3; b_in = 16'h8001; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0; p = '0;
      for (int c = 1; c <= 20; c++) begin
         if (c <= 16) begin
            k = (c - 1) / 2;
            exp_d = (k == 0) ? 2'b01 : (k == 7) ? 2'b10 : 2'b00;
         end else begin
            exp_d = 2'b00;
         end
         checks++;
         if ({bh1, bl1} !== exp_d || cin1 !== 1'b0 || la1 !== 16'd3) begin
            failures++;
            $display("FAIL layer_ports c=%0d got=%b%b cin=%b A=%h exp=%b cin=0 A=0003", c, bh1, bl1, cin1, la1, exp_d);
         end
         if (done1) begin ndone++; p = product1; end
         @(posedge clk); #1;
      end
      checks++; if (ndone !== 1) begin failures++; $display("FAIL layer_done_count got=%0d exp=1", ndone); end
      checks++; if (p !== 32'hFFFE8003) begin failures++; $display("FAIL layer_product got=%h exp=fffe8003", p); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_lat0();
      test_ignored_start();
      test_midrun_reset();
      test_layer_ports();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/layer16x2_seq_mult_ctrl.md
# layer16x2_seq_mult_ctrl

Sequencing controller that turns the signed 16x2 partial-product layer into a full signed 16x16 multiplier. It processes the 16-bit multiplier two bits per step, drives the layer's A/B_low/B_high/cin inputs, and shift-accumulates the returned 18-bit layer_sum into a 32-bit product. It sits between a requester using a start/done handshake and one shared layer instance, at eight steps per product.

## Interface

- width1, default 16: operand width. Only 16 is supported; it fixes 8 steps and a 32-bit product.
- LAYER_LAT, default 1: cycles from layer input change to valid layer_sum. Legal values are 0 (combinational layer) or 1 (registered layer).

- clk, input, 1: clock. All state updates on the rising edge.
- rst, input, 1: reset. Synchronous and active-high.
- start, input, 1: request. Accepted only when ready=1.
- a_in, input, 16: signed multiplicand. Sampled on accept.
- b_in, input, 16: signed multiplier. Sampled on accept.
- ready, output, 1: high in IDLE only.
- busy, output, 1: high in RUN and WAIT.
- done, output, 1: one-cycle pulse; product is valid from this cycle.
- product, output, 32: signed a_in*b_in. Held until the next accepted start.
- layer_A, output, 16: multiplicand to the layer.
- layer_B_low, output, 1: low bit of the current digit.
- layer_B_high, output, 1: high bit of the current digit.
- layer_cin, output, 1: layer carry-in. Constant 0.
- layer_sum, input, 18: signed partial product returned by the layer.

## Operation

- States: IDLE, RUN, WAIT, DONE.
- IDLE
  - ready=1.
  - start=1: latch a_reg=a_in and b_reg=b_in, clear acc (32-bit signed) and step k (3-bit). Go to RUN.
- RUN (step k)
  - layer_A=a_reg.
  - layer_B_high=b_reg[2k+1].
  - layer_B_low=b_reg[2k].
- Layer contract: layer_sum = sign-extended A × {B_high,B_low}, with the 2-bit digit treated as unsigned 0..3.
- Partial product pp_k
  - k<7: pp = sext32(layer_sum).
  - k=7: pp = sext32(layer_sum) − (b_reg[15] ? sext32(a_reg)<<2 : 0). This applies the negative weight of the sign bit.
- Accumulate: acc ← acc + (pp << 2k), modulo 2^32.
- LAYER_LAT=0: accumulate at the end of RUN.
  - k<7: k++ and stay in RUN.
  - k=7: go to DONE.
- LAYER_LAT=1
  - RUN → WAIT, with layer inputs held.
  - Accumulate at the end of WAIT.
  - k<7: k++ and go to RUN.
  - k=7: go to DONE.
- DONE
  - done=1 for exactly one cycle.
  - product ← final acc, loaded on the edge entering DONE, so it is visible in the DONE cycle.
  - Next state: IDLE.
- Outside RUN/WAIT: layer_B_low=layer_B_high=0 and layer_A=a_reg. No spurious layer activity.
- start while ready=0 (RUN, WAIT or DONE): ignored, not queued.
- a_in/b_in changes after accept: no effect.

## Timing

- Reset values: state=IDLE, ready=1, busy=0, done=0, product=0, layer_A=0, layer_B_low=0, layer_B_high=0, layer_cin=0, acc=0, k=0.
- Accept edge is cycle 0. RUN begins in cycle 1.
- done latency: high in cycle 8·(1+LAYER_LAT)+1, i.e. cycle 17 for LAYER_LAT=1 and cycle 9 for LAYER_LAT=0.
- ready: returns to 1 the cycle after done. Back-to-back throughput is one product per 8·(1+LAYER_LAT)+2 cycles.
- layer_sum: sampled only at the end of the last cycle of each step. It is don't-care otherwise.
- rst=1 in any state, including mid-step: next cycle returns to the reset values. Partial acc is discarded and no done is emitted.
- Overflow: none possible, since the full signed 16x16 result fits in 32 bits. acc wraps modulo 2^32 internally only during correction arithmetic.

## Test plan

Bench uses the behavioral layer model above, LAYER_LAT=1 unless noted.

- a=3, b=5 -> done in cycle 17, product=0x0000000F, ready back in cycle 18.
- a=−32768, b=−32768 -> product=0x40000000. a=−1, b=1 -> product=0xFFFFFFFF.
- a=12345, b=−2 -> product=0xFFFF9F8E (−24690). Rerun with LAYER_LAT=0 -> same product, done in cycle 9.
- Accept a=7, b=9, then pulse start with a=1, b=1 in cycle 4 -> ignored; product=63, exactly one done pulse.
- Accept a=100, b=100, assert rst in cycle 6 -> next cycle ready=1, busy=0, product=0, no done. A new start with a=2, b=−3 -> product=0xFFFFFFFA.
- Layer port check, b=0x8001 -> layer_B_high/layer_B_low go 01 at k=0, 00 at k=1..6, 10 at k=7; layer_cin=0 throughout; product = a·(−32767).
